// File: rtl/hazard_ctrl_pkg.sv
// Shared parameters, widths and FSM encoding for the hazard controller and its scoreboard.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_LEN = 5;
  localparam int WIDTH        = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int FLUSH_CNT_W  = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with an outstanding-write counter.
// Register 0 is hard-wired to never be pending.
module reg_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_LEN = hazard_ctrl_pkg::REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [REG_ADDR_LEN-1:0] set_addr,
  input  logic                    clr_en,
  input  logic [REG_ADDR_LEN-1:0] clr_addr,
  input  logic [REG_ADDR_LEN-1:0] src1_addr,
  input  logic [REG_ADDR_LEN-1:0] src2_addr,
  input  logic [REG_ADDR_LEN-1:0] dst_addr,
  output logic                    src1_pend,
  output logic                    src2_pend,
  output logic                    dst_pend,
  output logic [REG_ADDR_LEN:0]   inflight
);

  localparam int NREG = 1 << REG_ADDR_LEN;

  logic [NREG-1:0]       pend_q;
  logic [NREG-1:0]       pend_d;
  logic [REG_ADDR_LEN:0] inflight_q;
  logic                  set_v;
  logic                  clr_v;
  logic                  set_new;

  always_comb begin
    set_v   = set_en && (set_addr != '0);
    clr_v   = clr_en && pend_q[clr_addr];
    // A set only adds to the count if the bit was free or is being freed this cycle.
    set_new = set_v && (!pend_q[set_addr] || (clr_v && (clr_addr == set_addr)));
    pend_d  = pend_q;
    if (clr_v) pend_d[clr_addr] = 1'b0;
    if (set_v) pend_d[set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      inflight_q <= '0;
    end else begin
      pend_q <= pend_d;
      case ({set_new, clr_v})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign src1_pend = pend_q[src1_addr];
  assign src2_pend = pend_q[src2_addr];
  assign dst_pend  = pend_q[dst_addr];
  assign inflight  = inflight_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW/WAW stall, branch flush and HALT sequencing.
// Optional macro WB_BYPASS_EN lets a source issue in the same cycle as its writeback.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_LEN = hazard_ctrl_pkg::REG_ADDR_LEN,
  parameter int FLUSH_CYCLES = hazard_ctrl_pkg::FLUSH_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic                    src1_en,
  input  logic                    src2_en,
  input  logic [REG_ADDR_LEN-1:0] src1_addr,
  input  logic [REG_ADDR_LEN-1:0] src2_addr,
  input  logic                    dst_en,
  input  logic [REG_ADDR_LEN-1:0] dst_addr,
  input  logic                    id_halt,
  input  logic                    br_taken,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  output logic                    is_stall,
  output logic                    is_flush,
  output logic                    issue,
  output logic                    halted,
  output logic [REG_ADDR_LEN:0]   inflight
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE  = FLUSH_CNT_W'(1);

  state_e                 state_q;
  state_e                 state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q;
  logic [FLUSH_CNT_W-1:0] cnt_d;
  logic                   src1_pend;
  logic                   src2_pend;
  logic                   dst_pend;
  logic                   src1_byp;
  logic                   src2_byp;
  logic                   hazard;
  logic                   stall_c;
  logic                   flush_c;
  logic                   issue_c;
  logic                   halted_c;

  reg_scoreboard #(
    .REG_ADDR_LEN(REG_ADDR_LEN)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_c && dst_en),
    .set_addr (dst_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .src1_addr(src1_addr),
    .src2_addr(src2_addr),
    .dst_addr (dst_addr),
    .src1_pend(src1_pend),
    .src2_pend(src2_pend),
    .dst_pend (dst_pend),
    .inflight (inflight)
  );

`ifdef WB_BYPASS_EN
  assign src1_byp = wb_en && (wb_addr == src1_addr);
  assign src2_byp = wb_en && (wb_addr == src2_addr);
`else
  assign src1_byp = 1'b0;
  assign src2_byp = 1'b0;
`endif

  // WAW always looks at the registered bit; only sources may use the bypass.
  assign hazard = id_valid && ((src1_en && src1_pend && !src1_byp) ||
                               (src2_en && src2_pend && !src2_byp) ||
                               (dst_en && dst_pend));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    issue_c  = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      RUN: begin
        if (br_taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
          flush_c = 1'b1;
        end else begin
          stall_c = hazard;
          issue_c = id_valid && !hazard;
          if (issue_c && id_halt) state_d = HALT;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (br_taken) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALT: begin
        halted_c = 1'b1;
        stall_c  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign is_stall = rst_n && stall_c;
  assign is_flush = rst_n && flush_c;
  assign issue    = rst_n && issue_c;
  assign halted   = rst_n && halted_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a behavioural scoreboard model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid = 1'b0, src1_en = 1'b0, src2_en = 1'b0, dst_en = 1'b0;
  logic [AW-1:0] src1_addr = '0, src2_addr = '0, dst_addr = '0, wb_addr = '0;
  logic          id_halt = 1'b0, br_taken = 1'b0, wb_en = 1'b0;
  logic          is_stall, is_flush, issue, halted;
  logic [AW:0]   inflight;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: set of pending registers, remaining flush cycles, halt flag.
  logic [31:0] m_pend;
  int          m_flush_left;
  bit          m_halted;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_LEN(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .src1_en(src1_en), .src2_en(src2_en), .src1_addr(src1_addr), .src2_addr(src2_addr),
    .dst_en(dst_en), .dst_addr(dst_addr), .id_halt(id_halt), .br_taken(br_taken),
    .wb_en(wb_en), .wb_addr(wb_addr), .is_stall(is_stall), .is_flush(is_flush),
    .issue(issue), .halted(halted), .inflight(inflight)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit s1e, input int s1, input bit s2e, input int s2,
                       input bit de, input int d, input bit h, input bit br,
                       input bit we, input int wa);
    id_valid = v;  src1_en = s1e; src1_addr = AW'(s1); src2_en = s2e; src2_addr = AW'(s2);
    dst_en = de;   dst_addr = AW'(d); id_halt = h; br_taken = br;
    wb_en = we;    wb_addr = AW'(wa);
  endtask

  task automatic tick();
    bit e_stall, e_flush, e_issue, e_halt, haz, s1p, s2p;
    #1;
    e_stall = 0; e_flush = 0; e_issue = 0; e_halt = 0;
    if (m_halted) begin
      e_halt = 1; e_stall = 1;
    end else if (br_taken || m_flush_left > 0) begin
      e_flush = 1;
    end else begin
      s1p = m_pend[src1_addr];
      s2p = m_pend[src2_addr];
`ifdef WB_BYPASS_EN
      if (wb_en && wb_addr == src1_addr) s1p = 0;
      if (wb_en && wb_addr == src2_addr) s2p = 0;
`endif
      haz = id_valid && ((src1_en && s1p) || (src2_en && s2p) || (dst_en && m_pend[dst_addr]));
      e_stall = haz;
      e_issue = id_valid && !haz;
    end
    check("is_stall", {7'b0, is_stall}, {7'b0, e_stall});
    check("is_flush", {7'b0, is_flush}, {7'b0, e_flush});
    check("issue",    {7'b0, issue},    {7'b0, e_issue});
    check("halted",   {7'b0, halted},   {7'b0, e_halt});
    check("inflight", {1'b0, inflight}, 8'($countones(m_pend)));
    @(posedge clk);
    if (wb_en) m_pend[wb_addr] = 1'b0;
    if (e_issue && dst_en && dst_addr != 0) m_pend[dst_addr] = 1'b1;
    if (e_issue && id_halt) m_halted = 1;
    if (!m_halted && br_taken) m_flush_left = FC - 1;
    else if (m_flush_left > 0) m_flush_left--;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_stall",    {7'b0, is_stall}, 8'd0);
    check("rst_flush",    {7'b0, is_flush}, 8'd0);
    check("rst_issue",    {7'b0, issue},    8'd0);
    check("rst_halted",   {7'b0, halted},   8'd0);
    check("rst_inflight", {1'b0, inflight}, 8'd0);
    m_pend = '0; m_flush_left = 0; m_halted = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    m_pend = '0; m_flush_left = 0; m_halted = 0;
    #2;
    do_reset();

    // RAW on r3, released by writeback
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 3); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("r3_inflight", {1'b0, inflight}, 8'd0);

    // Branch while stalled on r5
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    check("r5_stall_after_flush", {7'b0, is_stall}, 8'd1);

    // WAW on r7 with simultaneous writeback, then a non-pending writeback
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7); tick();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12); tick();

    // Back-to-back branches reload the flush counter
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();

    // HALT, writeback during HALT, then reset
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0); tick();
    drive(1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5); tick(); tick();
    check("halt_held", {7'b0, halted}, 8'd1);
    do_reset();

    // r0 is never pending
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0); tick();

    // Reset asserted in the first FLUSH cycle
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    tick(); tick();

    // Randomized traffic with periodic resets
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      if (i % 64 == 63) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
